// File: rtl/ps_pkg.sv
// Shared types and constants for the multi-channel NoC packet endpoint.
package ps_pkg;

  // Command opcode carried in the top two bits of a header byte
  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_WR  = 2'b01,
    OP_RD  = 2'b10,
    OP_ST  = 2'b11
  } op_t;

  // Outbound idle code (driven with ctl=1)
  localparam logic [31:0] IDLE_CODE = 32'h0;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LEN,
    R_WDATA
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_HDR,
    T_CNT,
    T_DATA,
    T_DROP
  } tx_state_t;

  // Request fields are sized for the widest supported link; users cast down
  localparam int unsigned REQ_CHW = 16;
  localparam int unsigned REQ_LW  = 32;

  typedef struct packed {
    op_t                op;
    logic [REQ_CHW-1:0] ch;
    logic [REQ_LW-1:0]  len;
  } req_t;

endpackage

// File: rtl/ps_chan_fifo.sv
// Single-clock byte FIFO for one channel; push on full is honoured only with a concurrent pop.
module ps_chan_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata_c,
  output logic          o_full_c,
  output logic          o_empty_c,
  output logic [DW-1:0] o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [DW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full_c  = (r_count == DW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign w_pop     = i_pop & ~o_empty_c;
  assign w_push    = i_push & (~o_full_c | w_pop);
  assign o_rdata_c = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap modulo DEPTH; count tracks push/pop balance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + DW'(1);
        2'b01:   r_count <= r_count - DW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps_mc.sv
// Multi-channel NoC packet endpoint: RX command decode, per-channel FIFOs, framed TX responses.
module ps_mc
  import ps_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          noc_to_dev_ctl,
  input  logic [DW-1:0] noc_to_dev_data,
  output logic          noc_from_dev_ctl,
  output logic [DW-1:0] noc_from_dev_data
);

  localparam int unsigned CW = $clog2(NCH);

  // RX side
  rx_state_t     r_rx_state;
  op_t           r_rx_op;
  logic [CW-1:0] r_rx_ch;
  logic [DW-1:0] r_rx_left;
  op_t           w_hdr_op;
  logic [CW-1:0] w_hdr_ch;
  logic          w_hdr_ok;
  logic          w_wr_v;
  logic          w_req_v;
  req_t          w_req;

  // TX side
  tx_state_t     r_tx_state;
  req_t          r_req;
  logic [DW-1:0] r_tx_n;
  logic [DW-1:0] r_tx_rem;
  logic          r_pend_v;
  req_t          r_pend;
  logic [CW-1:0] w_tx_ch;
  logic          w_tx_free;
  logic          w_tx_done;
  logic          w_tx_pop;
  logic          w_take_new;
  logic          w_pend_take;
  logic          w_pend_load;
  logic          w_req_drop;
  logic [DW-1:0] w_occ;
  logic [DW-1:0] w_n;
  logic [DW-1:0] w_head;
  logic [DW-1:0] w_drop_cur;
  logic          w_unused_req;

  // Per-channel
  logic [NCH-1:0] w_push;
  logic [NCH-1:0] w_pop;
  logic [NCH-1:0] w_full;
  logic [NCH-1:0] w_empty;
  logic [NCH-1:0] w_drop_inc;
  logic [NCH-1:0] w_drop_clr;
  logic [DW-1:0]  w_count [NCH];
  logic [DW-1:0]  w_rdata [NCH];
  logic [DW-1:0]  r_drop  [NCH];

  function automatic logic [DW-1:0] f_hdr(input op_t op, input logic [CW-1:0] ch);
    return {op, (DW-2)'(ch)};
  endfunction

  // Header decode; out-of-range channels behave as NOP
  assign w_hdr_op = op_t'(noc_to_dev_data[DW-1:DW-2]);
  assign w_hdr_ch = noc_to_dev_data[CW-1:0];
  assign w_hdr_ok = (w_hdr_op != OP_NOP) && (32'(w_hdr_ch) < NCH);

  assign w_wr_v  = (r_rx_state == R_WDATA) && !noc_to_dev_ctl;
  assign w_req_v = (r_rx_state == R_LEN) && !noc_to_dev_ctl &&
                   ((r_rx_op == OP_RD) || (r_rx_op == OP_ST));
  assign w_req   = '{op: r_rx_op, ch: REQ_CHW'(r_rx_ch), len: REQ_LW'(noc_to_dev_data)};

  // RX FSM: header -> length -> optional write payload; ctl=1 always restarts decode
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= R_IDLE;
      r_rx_op    <= OP_NOP;
      r_rx_ch    <= '0;
      r_rx_left  <= '0;
    end else if (noc_to_dev_ctl) begin
      if (w_hdr_ok) begin
        r_rx_state <= R_LEN;
        r_rx_op    <= w_hdr_op;
        r_rx_ch    <= w_hdr_ch;
      end else begin
        r_rx_state <= R_IDLE;
      end
    end else begin
      case (r_rx_state)
        R_LEN: begin
          if ((r_rx_op == OP_WR) && (noc_to_dev_data != '0)) begin
            r_rx_state <= R_WDATA;
            r_rx_left  <= noc_to_dev_data;
          end else begin
            r_rx_state <= R_IDLE;
          end
        end
        R_WDATA: begin
          r_rx_left <= r_rx_left - DW'(1);
          if (r_rx_left == DW'(1)) r_rx_state <= R_IDLE;
        end
        default: r_rx_state <= R_IDLE;
      endcase
    end
  end

  // TX control: completion, pop, and request routing to TX / pending slot / drop
  assign w_tx_ch     = CW'(r_req.ch);
  assign w_occ       = w_count[w_tx_ch];
  assign w_head      = w_rdata[w_tx_ch];
  assign w_drop_cur  = r_drop[w_tx_ch];
  assign w_tx_done   = ((r_tx_state == T_CNT) && (r_req.op == OP_RD) && (r_tx_n == '0)) ||
                       ((r_tx_state == T_DATA) && (r_tx_rem == '0)) ||
                       (r_tx_state == T_DROP);
  assign w_tx_pop    = ((r_tx_state == T_CNT) && (r_req.op == OP_RD) && (r_tx_n != '0)) ||
                       ((r_tx_state == T_DATA) && (r_tx_rem != '0));
  assign w_tx_free   = (r_tx_state == T_IDLE) || w_tx_done;
  assign w_take_new  = w_req_v && !r_pend_v && w_tx_free;
  assign w_pend_take = w_tx_free && r_pend_v;
  assign w_pend_load = w_req_v && !w_take_new && (!r_pend_v || w_pend_take);
  assign w_req_drop  = w_req_v && !w_take_new && !w_pend_load;
  assign w_unused_req = ^{r_req, r_pend};

  // Response count: READ is clipped to current occupancy, STATUS reports occupancy
  always_comb begin
    w_n = w_occ;
    if ((r_req.op == OP_RD) && (r_req.len < REQ_LW'(w_occ))) w_n = DW'(r_req.len);
  end

  // Per-channel push/pop strobes and drop-counter events
  always_comb begin
    w_push     = '0;
    w_pop      = '0;
    w_drop_inc = '0;
    w_drop_clr = '0;
    for (int c = 0; c < NCH; c++) begin
      w_push[c]     = w_wr_v && (r_rx_ch == CW'(c));
      w_pop[c]      = w_tx_pop && (w_tx_ch == CW'(c)) && !w_empty[c];
      w_drop_inc[c] = (w_push[c] && w_full[c] && !w_pop[c]) ||
                      (w_req_drop && (r_rx_ch == CW'(c)));
      w_drop_clr[c] = (r_tx_state == T_CNT) && (r_req.op == OP_ST) && (w_tx_ch == CW'(c));
    end
  end

  // Drop counters: saturating, cleared when reported (a same-cycle drop leaves 1)
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        r_drop[c] <= '0;
      end else if (w_drop_clr[c]) begin
        r_drop[c] <= w_drop_inc[c] ? DW'(1) : '0;
      end else if (w_drop_inc[c] && (r_drop[c] != '1)) begin
        r_drop[c] <= r_drop[c] + DW'(1);
      end
    end
  end

  // TX FSM with registered outputs: header, count, then data or drop byte
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state        <= T_IDLE;
      noc_from_dev_ctl  <= 1'b1;
      noc_from_dev_data <= DW'(IDLE_CODE);
      r_req             <= '0;
      r_tx_n            <= '0;
      r_tx_rem          <= '0;
      r_pend_v          <= 1'b0;
      r_pend            <= '0;
    end else begin
      if (w_pend_load) begin
        r_pend   <= w_req;
        r_pend_v <= 1'b1;
      end else if (w_pend_take) begin
        r_pend_v <= 1'b0;
      end

      if (w_tx_free) begin
        if (r_pend_v) begin
          r_req             <= r_pend;
          r_tx_state        <= T_HDR;
          noc_from_dev_ctl  <= 1'b1;
          noc_from_dev_data <= f_hdr(r_pend.op, CW'(r_pend.ch));
        end else if (w_take_new) begin
          r_req             <= w_req;
          r_tx_state        <= T_HDR;
          noc_from_dev_ctl  <= 1'b1;
          noc_from_dev_data <= f_hdr(w_req.op, r_rx_ch);
        end else begin
          r_tx_state        <= T_IDLE;
          noc_from_dev_ctl  <= 1'b1;
          noc_from_dev_data <= DW'(IDLE_CODE);
        end
      end else begin
        case (r_tx_state)
          T_HDR: begin
            r_tx_state        <= T_CNT;
            noc_from_dev_ctl  <= 1'b0;
            noc_from_dev_data <= w_n;
            r_tx_n            <= w_n;
          end
          T_CNT: begin
            noc_from_dev_ctl <= 1'b0;
            if (r_req.op == OP_RD) begin
              r_tx_state        <= T_DATA;
              noc_from_dev_data <= w_head;
              r_tx_rem          <= r_tx_n - DW'(1);
            end else begin
              r_tx_state        <= T_DROP;
              noc_from_dev_data <= w_drop_cur;
            end
          end
          T_DATA: begin
            noc_from_dev_ctl  <= 1'b0;
            noc_from_dev_data <= w_head;
            r_tx_rem          <= r_tx_rem - DW'(1);
          end
          default: r_tx_state <= T_IDLE;
        endcase
      end
    end
  end

  // Channel FIFOs
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    ps_chan_fifo #(
      .DW   (DW),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .i_push   (w_push[g]),
      .i_wdata  (noc_to_dev_data),
      .i_pop    (w_pop[g]),
      .o_rdata_c(w_rdata[g]),
      .o_full_c (w_full[g]),
      .o_empty_c(w_empty[g]),
      .o_count  (w_count[g])
    );
  end

endmodule

// File: doc/ps_mc.md
Name: ps_mc

Overview:
- Parametrised, multi-channel successor to the single-port NoC packet endpoint.
- Attaches to the NOCI link and holds NCH independent byte FIFOs.
- Hosts write bursts into a channel, read them back as framed response packets, and query per-channel occupancy and drop counts.
- The receive path is never backpressured. The transmit path emits one byte per clock.

Parameters:
- DW, 8: link data width. DW >= 8.
- NCH, 4: number of channels, 2..2^(DW-2).
- DEPTH, 16: entries per channel FIFO, 2..2^DW-1.
- CW, $clog2(NCH): channel-id width (derived, localparam).

Ports:
- clk, in, 1: clock; all logic on rising edge.
- reset, in, 1: synchronous, active-high reset.
- noc_to_dev_ctl, in, 1: 1 = command/header byte; 0 = payload byte.
- noc_to_dev_data, in, DW: inbound byte.
- noc_from_dev_ctl, out, 1: 1 = response header or idle; 0 = payload.
- noc_from_dev_data, out, DW: outbound byte.

Behaviour:
- Header byte (ctl=1) fields:
  - op = data[DW-1:DW-2]: 00 NOP/idle, 01 WRITE, 10 READ, 11 STATUS.
  - ch = data[CW-1:0]. Channel ids >= NCH are treated as NOP.
- Every command is followed by exactly one length byte L (ctl=0). WRITE then carries L payload bytes. NOP has no length byte.
- Reset: both outputs registered. noc_from_dev_ctl=1 and noc_from_dev_data=0 (idle code) in the cycle after reset is seen high and until the first response. All FIFOs empty, drop counters 0, both FSMs idle, pending slot empty.
- RX FSM:
  - R_IDLE -> R_LEN on a valid header.
  - R_LEN -> R_WDATA for WRITE with L>0; otherwise back to R_IDLE.
  - R_WDATA stays until L bytes are consumed, then returns to R_IDLE.
  - Any ctl=1 byte in R_LEN or R_WDATA aborts the current command and is decoded as a new header in the same cycle.
- WRITE: each payload byte is pushed if the channel is not full. Otherwise it is discarded and that channel's drop counter increments, saturating at 2^DW-1. A push is visible in occupancy the next cycle.
- READ/STATUS: when the length byte arrives, the request {op, ch, L} goes to the TX FSM if it is in T_IDLE. Otherwise it goes into a one-entry pending slot. If the slot is already full, the request is dropped and the channel drop counter increments.
- TX FSM:
  - T_IDLE: output idle code.
  - T_HDR: ctl=1, data = request header byte echoed.
  - T_CNT: ctl=0, data = n.
    - READ: n = min(L, occupancy sampled in T_HDR).
    - STATUS: n = occupancy.
  - READ -> T_DATA: n bytes, one per cycle, ctl=0, popped in order. Skipped if n=0.
  - STATUS -> T_DROP: one byte = drop counter, which is then cleared. An increment in the same cycle leaves the counter at 1.
  - After the last byte: go to T_HDR if the pending slot is valid (consuming it), else T_IDLE.
- Latency: READ length byte accepted at cycle t -> header on output at t+1 when TX is idle. Data follows back-to-back.
- Simultaneous push and pop on one channel:
  - Both occur. Occupancy is unchanged.
  - A full FIFO accepts the push when it also pops.
  - An empty FIFO never pops: n already excludes this case.
- FIFO pointers wrap modulo DEPTH. Occupancy is DW bits wide.
- Reset mid-packet: the response is truncated, the output returns to idle the next cycle, and all state is cleared.

Decomposition:
- Package ps_pkg holds:
  - opcode enum (OP_NOP, OP_WR, OP_RD, OP_ST);
  - IDLE_CODE;
  - rx_state_t and tx_state_t enums;
  - request struct {op, ch, len}.
- One sub-module, ps_chan_fifo (DW, DEPTH): single clock, push/pop/full/empty/count. Instantiated NCH times via generate.
- Top level holds the FSMs, pending slot and drop counters.

Test Plan:
- WRITE ch2 L=3 {0x11,0x22,0x33}, then READ ch2 L=3 -> output 0x82(ctl=1), 0x03, 0x11, 0x22, 0x33, then idle 0x00(ctl=1).
- DEPTH=16: WRITE ch0 L=20 bytes, then STATUS ch0 -> 0xC0, 0x10, 0x04. A second STATUS returns drop count 0x00.
- READ ch1 L=5 with 2 entries -> header, count 0x02, 2 bytes. A READ on an empty channel returns count 0x00 and no data.
- WRITE ch3 L=4, but a header arrives after 2 bytes -> occupancy 2, new header decoded that cycle.
- Three back-to-back READs while TX is busy -> the first two are served in order, the third is dropped and the drop count increments.
- Assert reset during a READ data phase -> idle code the next cycle, all occupancies 0 afterwards.
